dual_ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that acts as the initiator on the two-port RAM interface (read, write, rd_addr, wr_addr, data_in, data_out).
- Converts push/pop requests into RAM write/read strobes and addresses.
- Tracks occupancy and reports full/empty, threshold and error flags.
- Sits between a producer/consumer pair and one external two-port RAM instance. The RAM has a 1-cycle registered read and is reset by the same reset.

---
 rtl/dual_ram_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_dual_ram_fifo_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_ram_fifo_ctrl.sv
// FIFO controller driving an external two-port RAM with a 1-cycle read.
// Tracks occupancy, threshold flags and sticky overflow/underflow errors.
module dual_ram_fifo_ctrl #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_DEPTH     = 16,
  parameter int ADDR_SIZE     = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [RAM_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err,
  output logic                 ram_write,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  output logic                 ram_read,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_SIZE:0] DEPTH_C =
    (ADDR_SIZE+1)'(RAM_DEPTH);
  localparam logic [ADDR_SIZE:0] AFULL_C =
    (ADDR_SIZE+1)'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] AEMPTY_C =
    (ADDR_SIZE+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_SIZE-1:0] LAST_C =
    ADDR_SIZE'(RAM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ONE_P =
    ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0] ONE_C =
    (ADDR_SIZE+1)'(1);

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 wr_acc;
  logic                 rd_acc;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // Reset masks the strobes so the RAM never sees a stray access.
  assign wr_acc = wr_en & ~full & ~reset;
  assign rd_acc = rd_en & ~empty & ~reset;

  assign ram_write   = wr_acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_wdata   = wr_data;
  assign ram_read    = rd_acc;
  assign ram_rd_addr = rd_ptr;
  assign rd_data     = ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + ONE_P;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (rd_acc) begin
      rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + ONE_P;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        wr_acc & ~rd_acc: count <= count + ONE_C;
        rd_acc & ~wr_acc: count <= count - ONE_C;
        default:          count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
    end
  end

  // A new violation takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en & empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_ram_fifo_ctrl.sv
// Directed bench for dual_ram_fifo_ctrl with a behavioural two-port RAM.
// Expected values are hand-computed or come from a small queue model.
module tb_dual_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;
  logic       ram_write;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_wdata;
  logic       ram_read;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rdata;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dual_ram_fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err),
    .ram_write    (ram_write),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wdata    (ram_wdata),
    .ram_read     (ram_read),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rdata    (ram_rdata)
  );

  // Two-port RAM: registered read, output cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_rdata <= '0;
    end else begin
      if (ram_write) mem[ram_wr_addr] <= ram_wdata;
      if (ram_read) ram_rdata <= mem[ram_rd_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_b;
  int         mcount;
  bit         w;
  bit         r;

  initial begin
    reset   = 1'b1;
    wr_data = '0;
    idle();
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    check("rst_ram_write", 32'(ram_write), 0);
    check("rst_ram_read", 32'(ram_read), 0);
    step();
    step();
    idle();
    reset = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);

    // Three pushes, three back-to-back pops
    wr_en = 1'b1;
    wr_data = 8'h11; step();
    wr_data = 8'h22; step();
    wr_data = 8'h33; step();
    wr_en = 1'b0;
    check("t1_count3", 32'(count), 3);
    rd_en = 1'b1;
    #1;
    check("t1_ram_read", 32'(ram_read), 1);
    check("t1_no_valid_yet", 32'(rd_valid), 0);
    step();
    check("t1_v0", 32'(rd_valid), 1);
    check("t1_d0", 32'(rd_data), 32'h11);
    step();
    check("t1_v1", 32'(rd_valid), 1);
    check("t1_d1", 32'(rd_data), 32'h22);
    rd_en = 1'b0;
    exp_b = 8'h33;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t1_v2", 32'(rd_valid), 1);
    check("t1_d2", 32'(rd_data), 32'(exp_b));
    step();
    check("t1_v_end", 32'(rd_valid), 0);
    check("t1_count0", 32'(count), 0);
    check("t1_empty", 32'(empty), 1);
    check("t1_unf", 32'(underflow), 0);

    // Fill to full, overflow attempt, drain
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      step();
      check("t2_afull", 32'(almost_full), 32'(i >= 13));
      check("t2_aempty", 32'(almost_empty), 32'(i <= 1));
    end
    check("t2_full", 32'(full), 1);
    check("t2_count16", 32'(count), 16);
    wr_data = 8'hAA;
    #1;
    check("t2_ovf_no_write", 32'(ram_write), 0);
    step();
    wr_en = 1'b0;
    check("t2_ovf", 32'(overflow), 1);
    check("t2_count_hold", 32'(count), 16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("t2_v", 32'(rd_valid), 1);
      check("t2_d", 32'(rd_data), 32'(i));
    end
    rd_en = 1'b0;
    step();
    check("t2_empty", 32'(empty), 1);
    check("t2_v_end", 32'(rd_valid), 0);
    check("t2_ovf_sticky", 32'(overflow), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 0);

    // Simultaneous push/pop on empty
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h5A;
    #1;
    check("t3_write", 32'(ram_write), 1);
    check("t3_read", 32'(ram_read), 0);
    step();
    wr_en = 1'b0;
    check("t3_unf", 32'(underflow), 1);
    check("t3_count1", 32'(count), 1);
    check("t3_v0", 32'(rd_valid), 0);
    step();
    rd_en = 1'b0;
    check("t3_v", 32'(rd_valid), 1);
    check("t3_d", 32'(rd_data), 32'h5A);
    check("t3_count0", 32'(count), 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t3_unf_clr", 32'(underflow), 0);

    // Simultaneous push/pop on full
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(8'h30 + i);
      step();
    end
    check("t4_full", 32'(full), 1);
    wr_data = 8'hEE;
    rd_en = 1'b1;
    #1;
    check("t4_write", 32'(ram_write), 0);
    check("t4_read", 32'(ram_read), 1);
    step();
    idle();
    check("t4_count15", 32'(count), 15);
    check("t4_ovf", 32'(overflow), 1);
    check("t4_d", 32'(rd_data), 32'h30);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 0);
    rd_en = 1'b1;
    for (int i = 1; i < 16; i++) begin
      step();
      check("t4_drain", 32'(rd_data), 32'(8'h30 + i));
    end
    rd_en = 1'b0;
    step();
    check("t4_empty", 32'(empty), 1);

    // Wrap: 40 pushes with occupancy held in 1..5
    mcount = 0;
    for (int n = 0, c = 0; n < 40 || mcount > 0; c++) begin
      w = (n < 40) && (mcount < 5) && ((c % 3) != 2);
      r = (mcount >= 2) || (n == 40 && mcount > 0);
      wr_en = w;
      rd_en = r;
      wr_data = 8'(8'h80 + n);
      step();
      if (w) begin
        q.push_back(8'(8'h80 + n));
        n++;
        mcount++;
      end
      if (r) begin
        exp_b = q.pop_front();
        mcount--;
        check("t5_v", 32'(rd_valid), 1);
        check("t5_d", 32'(rd_data), 32'(exp_b));
      end
      check("t5_count", 32'(count), 32'(mcount));
    end
    idle();
    step();
    check("t5_empty", 32'(empty), 1);

    // Reset mid-stream with a pop in flight
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t6_unf_set", 32'(underflow), 1);
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h60 + i);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t6_pop_valid", 32'(rd_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_v", 32'(rd_valid), 0);
    check("t6_count", 32'(count), 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_unf", 32'(underflow), 0);
    check("t6_ovf", 32'(overflow), 0);
    check("t6_rd_data", 32'(rd_data), 0);
    wr_en = 1'b1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t6_v_new", 32'(rd_valid), 1);
    check("t6_d_new", 32'(rd_data), 32'h77);
    step();
    check("t6_empty_end", 32'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
